// File: rtl/set_bit_scanner_pkg.sv
// Shared definitions for the set-bit scanner: FSM state encoding and default width.
package set_bit_scanner_pkg;

  localparam int DEFAULT_WIDTH = 128;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/set_bit_scanner_bit_prio_enc.sv
// Combinational priority encoder: finds the lowest (dir=0) or highest (dir=1)
// set bit of vec and returns its index plus a one-hot mask of that bit.
module bit_prio_enc
  import set_bit_scanner_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  input  logic             dir,
  output logic [IDXW-1:0]  idx,
  output logic             found,
  output logic [WIDTH-1:0] onehot
);

  // Scan order picks the winner: the last match written in the loop wins.
  always_comb begin
    // NOTE: defaults come first so every path assigns idx/found and no latch is inferred.
    idx   = '0;
    found = 1'b0;
    if (dir) begin
      // Ascending walk leaves the highest set bit as the final assignment.
      for (int i = 0; i < WIDTH; i++) begin
        if (vec[i]) begin
          // NOTE: blocking assignments inside always_comb; later iterations override earlier ones.
          idx   = IDXW'(i);
          found = 1'b1;
        end
      end
    end else begin
      // Descending walk leaves the lowest set bit as the final assignment.
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (vec[i]) begin
          idx   = IDXW'(i);
          found = 1'b1;
        end
      end
    end
  end

  assign onehot = found ? (WIDTH'(1) << idx) : '0;

endmodule

// File: rtl/set_bit_scanner.sv
// Set-bit scanner: accepts a vector, then emits the positions of its set bits
// one per output handshake, lowest-first or highest-first.
module set_bit_scanner
  import set_bit_scanner_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int IDXW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last,
  output logic             out_none
);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] rem;
  logic             dir_q;

  logic [IDXW-1:0]  enc_idx;
  logic             enc_found;
  logic [WIDTH-1:0] enc_onehot;
  logic             last_c;

  bit_prio_enc #(
    .WIDTH (WIDTH),
    .IDXW  (IDXW)
  ) u_enc (
    .vec    (rem),
    .dir    (dir_q),
    .idx    (enc_idx),
    .found  (enc_found),
    .onehot (enc_onehot)
  );

  // The current bit is the last one when nothing remains after clearing it;
  // an all-zero rem therefore also reports last.
  assign last_c = (rem & ~enc_onehot) == '0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: non-blocking assignments for all clocked state so every flop samples pre-edge values.
      state <= state_nxt;
    end
  end

  // Next-state and output decode, purely from registered state.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_idx   = '0;
    out_last  = 1'b0;
    out_none  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SCAN;
      end
      SCAN: begin
        out_valid = 1'b1;
        out_idx   = enc_idx;
        out_last  = last_c;
        out_none  = !enc_found;
        if (out_ready && last_c) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Remaining-bits register and latched direction: load on accept, clear the
  // emitted bit on each output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem   <= '0;
      dir_q <= 1'b0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        rem   <= in_data;
        dir_q <= in_dir;
      end
    end else if (out_ready) begin
      rem <= rem & ~enc_onehot;
    end
  end

endmodule

// File: tb/tb_set_bit_scanner.sv
// Testbench for set_bit_scanner: directed cases plus randomized vectors with
// random back-pressure, checked against a list-based reference model.
`timescale 1ns/1ps
module tb_set_bit_scanner;

  localparam int W  = 128;
  localparam int IW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_dir;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          out_none;

  int checks = 0;
  int errors = 0;

  // Expected beats for the vector under test: index, last, none.
  int   exp_idx_q[$];
  logic exp_last_q[$];
  logic exp_none_q[$];

  set_bit_scanner #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_none  (out_none)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: list of set-bit positions in scan order.
  task automatic build_expected(input logic [W-1:0] v, input logic d);
    exp_idx_q.delete();
    exp_last_q.delete();
    exp_none_q.delete();
    if (v == '0) begin
      exp_idx_q.push_back(0);
      exp_last_q.push_back(1'b1);
      exp_none_q.push_back(1'b1);
    end else begin
      for (int p = 0; p < W; p++) begin
        if (v[p]) begin
          if (d) exp_idx_q.push_front(p);
          else   exp_idx_q.push_back(p);
        end
      end
      foreach (exp_idx_q[k]) begin
        exp_last_q.push_back(k == exp_idx_q.size() - 1);
        exp_none_q.push_back(1'b0);
      end
    end
  endtask

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  // Offer one vector and consume every beat, stalling out_ready with the
  // given probability (percent) and for a fixed number of initial cycles.
  task automatic run_vector(input string name, input logic [W-1:0] v, input logic d,
                            input int stall_pct, input int first_stall);
    int k;
    int n;
    int guard;
    int hold;
    logic rdy;
    build_expected(v, d);
    n = exp_idx_q.size();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: in_ready=%b required 1", name, in_ready);
    end
    in_valid  = 1'b1;
    in_data   = v;
    in_dir    = d;
    out_ready = 1'b0;
    @(negedge clk);
    k = 0;
    guard = 0;
    hold = first_stall;
    while (k < n) begin
      checks++;
      if ({out_valid, out_idx, out_last, out_none, in_ready} !==
          {1'b1, IW'(exp_idx_q[k]), exp_last_q[k], exp_none_q[k], 1'b0}) begin
        errors++;
        $display("FAIL %s beat%0d: valid=%b idx=%0d last=%b none=%b in_ready=%b required 1 %0d %b %b 0",
                 name, k, out_valid, out_idx, out_last, out_none, in_ready,
                 exp_idx_q[k], exp_last_q[k], exp_none_q[k]);
      end
      if (hold > 0) begin
        rdy = 1'b0;
        hold--;
      end else begin
        rdy = ($urandom_range(99) >= stall_pct);
      end
      out_ready = rdy;
      // Junk on the input side while scanning must be ignored.
      in_valid  = (k == n - 1) ? 1'b0 : 1'($urandom_range(1));
      in_data   = rand_vec();
      in_dir    = 1'($urandom_range(1));
      @(negedge clk);
      if (rdy) k++;
      guard++;
      if (guard > 20 * n + 20) begin
        errors++;
        $display("FAIL %s timeout: beat %0d of %0d not consumed", name, k, n);
        break;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL %s done: out_valid=%b in_ready=%b required 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_dir    = 1'b0;
    out_ready = 1'b0;
    #12;
    checks++;
    if ({out_valid, out_idx, out_last, out_none, in_ready} !== {1'b0, IW'(0), 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: valid=%b idx=%0d last=%b none=%b in_ready=%b required 0 0 0 0 1",
               out_valid, out_idx, out_last, out_none, in_ready);
    end
    // Release with a vector already offered: accepted on the first edge.
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_data  = W'(1) << 5;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_idx, out_last, out_none} !== {1'b1, IW'(5), 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL first_accept: valid=%b idx=%0d last=%b none=%b required 1 5 1 0",
               out_valid, out_idx, out_last, out_none);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL first_done: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_directed();
    run_vector("d4444_lo", W'(4444), 1'b0, 0, 0);
    run_vector("d4444_hi", W'(4444), 1'b1, 0, 0);
    run_vector("zero", '0, 1'b0, 0, 0);
    run_vector("top_bit", W'(1) << 127, 1'b0, 0, 0);
    run_vector("d1213213", W'(1213213), 1'b0, 0, 0);
    run_vector("all_ones_hi", '1, 1'b1, 0, 0);
    run_vector("bit0_hi", W'(1), 1'b1, 0, 0);
  endtask

  task automatic test_stall();
    run_vector("stall8", W'(8), 1'b0, 0, 3);
    run_vector("stall4444", W'(4444), 1'b1, 0, 2);
  endtask

  task automatic test_reset_mid_scan();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = W'(4444);
    in_dir   = 1'b0;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if ({out_valid, out_idx} !== {1'b1, IW'(2)}) begin
      errors++;
      $display("FAIL midrst_beat0: valid=%b idx=%0d required 1 2", out_valid, out_idx);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, out_idx} !== {1'b1, IW'(3)}) begin
      errors++;
      $display("FAIL midrst_beat1: valid=%b idx=%0d required 1 3", out_valid, out_idx);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_idx, out_last, out_none, in_ready} !== {1'b0, IW'(0), 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL midrst_immediate: valid=%b idx=%0d last=%b none=%b in_ready=%b required 0 0 0 0 1",
               out_valid, out_idx, out_last, out_none, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        errors++;
        $display("FAIL midrst_quiet%0d: out_valid=%b in_ready=%b required 0 1", c, out_valid, in_ready);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] v;
    int kind;
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(9);
      if (kind == 0)      v = '0;
      else if (kind == 1) v = W'(1) << $urandom_range(W - 1);
      else                v = rand_vec() & rand_vec() & rand_vec();
      run_vector($sformatf("rand%0d", t), v, 1'($urandom_range(1)), 30, 0);
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 6; t++) begin
      run_vector($sformatf("b2b%0d", t), rand_vec() & rand_vec() & rand_vec() & rand_vec(),
                 1'(t % 2), 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid_scan();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/set_bit_scanner.md
SET_BIT_SCANNER -- requirements
Module: set_bit_scanner

Interface
REQ-001 Parameter WIDTH, default 128, is the scanned vector width; legal values are 2 to 1024.
REQ-002 Parameter IDXW, default $clog2(WIDTH), is the index width and is derived only, never overridden.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset is asynchronous and active-low.
REQ-005 Port in_valid, input, 1 bit: a vector is offered.
REQ-006 Port in_ready, output, 1 bit: the block accepts a vector.
REQ-007 Port in_data, input, WIDTH bits: the vector to scan.
REQ-008 Port in_dir, input, 1 bit: 0 = lowest-set-bit first, 1 = highest-set-bit first; sampled with in_data.
REQ-009 Port out_valid, output, 1 bit: out_idx, out_last and out_none are valid.
REQ-010 Port out_ready, input, 1 bit: the consumer takes the current index.
REQ-011 Port out_idx, output, IDXW bits: bit position of the current set bit.
REQ-012 Port out_last, output, 1 bit: the current index is the final one for this vector.
REQ-013 Port out_none, output, 1 bit: the accepted vector was all-zero.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and SCAN.
REQ-015 in_ready SHALL be 1 in IDLE and 0 in SCAN; there is no overlap between vectors.
REQ-016 An input handshake (in_valid && in_ready) SHALL latch in_data into a remaining register (rem), latch in_dir, and move the FSM to SCAN.
REQ-017 In SCAN, out_valid SHALL be 1; first index latency is exactly 1 cycle after the input handshake.
REQ-018 In SCAN with rem nonzero:
- out_idx = position of the lowest set bit of rem (dir 0) or the highest set bit (dir 1);
- out_last = 1 iff rem has exactly one set bit;
- out_none = 0.
REQ-019 In SCAN with rem zero (all-zero vector accepted): out_idx = 0, out_last = 1, out_none = 1.
REQ-020 An output handshake (out_valid && out_ready) SHALL clear bit out_idx in rem; if out_last = 1, the FSM returns to IDLE.
REQ-021 With out_ready held high, the block SHALL emit one index per cycle; a vector with N set bits occupies N SCAN cycles (1 cycle if N = 0).
REQ-022 While out_valid && !out_ready, out_idx, out_last, out_none and rem SHALL hold stable.
REQ-023 in_data and in_dir SHALL be ignored in SCAN.
REQ-024 Outputs SHALL be driven from registered state through combinational logic only, with no dependence on in_* in the same cycle.

Reset
REQ-025 Asserting rst_n low SHALL immediately force:
- FSM = IDLE, rem = 0, dir = 0;
- out_valid = 0, out_idx = 0, out_last = 0, out_none = 0, in_ready = 1.
REQ-026 Reset asserted mid-SCAN SHALL discard the remaining bits; no further indices are emitted after release.
REQ-027 The first input handshake SHALL be possible on the first rising clk edge after rst_n deasserts.

Structure
REQ-028 A shared package/header SHALL hold the state encodings (IDLE = 1'b0, SCAN = 1'b1) and the default WIDTH.
REQ-029 Sub-module bit_prio_enc SHALL be a parameterised (WIDTH, IDXW) combinational encoder with a dir input and outputs idx, found and onehot; it is instantiated once.
REQ-030 The onehot output of bit_prio_enc SHALL be used for the clear operation, and out_last SHALL be computed as (rem & ~onehot) == 0.

Verification
REQ-031 in_data=4444, dir 0, out_ready=1 -> indices 2,3,4,6,8,12 on consecutive cycles, out_last only with 12.
REQ-032 in_data=4444, dir 1 -> indices 12,8,6,4,3,2, out_last only with 2.
REQ-033 in_data=0 -> one beat with out_none=1, out_last=1, out_idx=0, then IDLE.
REQ-034 in_data=1<<127 (dir 0) -> single beat, out_idx=127, out_last=1; in_data=1213213 (dir 0) -> first index 0.
REQ-035 in_data=8, out_ready low for 3 cycles -> out_idx=3 held stable with out_valid=1 throughout; released on the first cycle out_ready=1.
REQ-036 in_data=4444, rst_n pulsed low after 2 beats -> outputs zero immediately, in_ready=1, no further beats.
